wb_write_queue: RTL

Write-back side front end of the register file in the pipelined CPU. Merges the in-order pipeline result with results from long-latency units (multiply/divide, late loads) onto the single register-file write port. Long-latency results are held in a small FIFO and drained only in cycles the pipeline does not write. A per-register pending scoreboard tells decode which source and destination registers still await a long-latency result.

---
 rtl/wb_write_queue_pkg.sv | 25 ++
 rtl/wb_wq_fifo.sv | 71 +++++++
 rtl/wb_write_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_write_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Long-latency results are carried through the FIFO as {wn, d} entries.
package wb_write_queue_pkg;

  localparam int WQ_DEPTH = 4;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] d;
  } wq_entry_t;

  // One-hot scoreboard mask for a register; r0 maps to no bit so it can never be pending.
  function automatic logic [31:0] reg_mask(input logic [REG_W-1:0] r);
    logic [31:0] m;
    if (r == 5'd0) begin
      m = 32'd0;
    end else begin
      m = 32'd1 << r;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_wq_fifo.sv
// Synchronous FIFO holding long-latency results until the write port is free.
// Push is ignored when full and pop when empty, so pointers cannot run past each other.
module wb_wq_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     i_push,
  input  wq_entry_t                i_push_data,
  input  logic                     i_pop,
  output wq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  // Entry storage; contents are meaningless until counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_head <= {PTR_W{1'b0}};
      r_tail <= {PTR_W{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write port arbiter: pipeline results pass straight through, queued
// long-latency results fill idle cycles, and a pending bitmap flags their destinations.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    a_we,
  input  logic [4:0]              a_wn,
  input  logic [31:0]             a_d,
  input  logic                    b_valid,
  input  logic [4:0]              b_wn,
  input  logic [31:0]             b_d,
  output logic                    b_ready,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rn,
  input  logic [4:0]              rna,
  input  logic [4:0]              rnb,
  output logic                    pend_a,
  output logic                    pend_b,
  output logic                    iss_pend,
  output logic [4:0]              wn,
  output logic [31:0]             d,
  output logic                    we,
  output logic [$clog2(DEPTH):0]  count
);

  logic       w_a_hit;
  logic       w_enq;
  logic       w_deq;
  logic       w_full;
  logic       w_empty;
  wq_entry_t  w_head;
  wq_entry_t  w_push_data;
  logic [31:0] r_pending;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_pending_nxt;

  assign w_a_hit     = a_we && (a_wn != 5'd0);
  // Ready looks only at occupancy; a dequeue in the same cycle does not make room early.
  assign b_ready     = !w_full;
  assign w_enq       = b_valid && !w_full && (b_wn != 5'd0);
  assign w_deq       = !w_a_hit && !w_empty;
  assign w_push_data = '{wn: b_wn, d: b_d};

  wb_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .clrn        (clrn),
    .i_push      (w_enq),
    .i_push_data (w_push_data),
    .i_pop       (w_deq),
    .o_head      (w_head),
    .o_count     (count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Write-port mux: pipeline first, then FIFO head, otherwise idle.
  always_comb begin
    we = 1'b0;
    wn = 5'd0;
    d  = 32'd0;
    if (w_a_hit) begin
      we = 1'b1;
      wn = a_wn;
      d  = a_d;
    end else if (!w_empty) begin
      we = 1'b1;
      wn = w_head.wn;
      d  = w_head.d;
    end else begin
      we = 1'b0;
      wn = 5'd0;
      d  = 32'd0;
    end
  end

  // Scoreboard next state; the set mask is OR-ed last so a same-edge issue beats a retire.
  always_comb begin
    w_set_mask    = 32'd0;
    w_clr_mask    = 32'd0;
    w_pending_nxt = r_pending;
    if (iss_valid) begin
      w_set_mask = reg_mask(iss_rn);
    end else begin
      w_set_mask = 32'd0;
    end
    if (w_deq) begin
      w_clr_mask = reg_mask(w_head.wn);
    end else begin
      w_clr_mask = 32'd0;
    end
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // Pending bitmap register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign pend_a   = (rna != 5'd0)    && r_pending[rna];
  assign pend_b   = (rnb != 5'd0)    && r_pending[rnb];
  assign iss_pend = (iss_rn != 5'd0) && r_pending[iss_rn];

endmodule
